// File: rtl/lsu_agu_pkg.sv
// Shared load/store parameters, opcode constants and the AGU payload layout.
package lsu_agu_pkg;

   localparam int unsigned XLEN             = 64;
   localparam int unsigned VIRTUAL_ADDR_LEN = 39;
   localparam int unsigned LS_OPCODE_WIDTH  = 4;
   localparam int unsigned ROB_INDEX_WIDTH  = 6;
   localparam int unsigned IMM_LEN          = 12;

   // Load opcodes
   localparam logic [LS_OPCODE_WIDTH-1:0] LDU_LB  = 4'h0;
   localparam logic [LS_OPCODE_WIDTH-1:0] LDU_LH  = 4'h1;
   localparam logic [LS_OPCODE_WIDTH-1:0] LDU_LW  = 4'h2;
   localparam logic [LS_OPCODE_WIDTH-1:0] LDU_LD  = 4'h3;
   localparam logic [LS_OPCODE_WIDTH-1:0] LDU_LBU = 4'h4;
   localparam logic [LS_OPCODE_WIDTH-1:0] LDU_LHU = 4'h5;
   localparam logic [LS_OPCODE_WIDTH-1:0] LDU_LWU = 4'h6;

   // Store opcodes
   localparam logic [LS_OPCODE_WIDTH-1:0] STU_SB  = 4'h8;
   localparam logic [LS_OPCODE_WIDTH-1:0] STU_SH  = 4'h9;
   localparam logic [LS_OPCODE_WIDTH-1:0] STU_SW  = 4'hA;
   localparam logic [LS_OPCODE_WIDTH-1:0] STU_SD  = 4'hB;

   // One op as carried from AGU into the address-check stage
   typedef struct packed {
      logic                        ls;
      logic [LS_OPCODE_WIDTH-1:0]  opcode;
      logic [XLEN-1:0]             data;
      logic [ROB_INDEX_WIDTH-1:0]  rob_index;
      logic [VIRTUAL_ADDR_LEN-1:0] addr;
      logic                        noncanon;
   } agu_payload_t;

endpackage

// File: rtl/lsu_agu_adder.sv
// Combinational address adder: base + sign-extended immediate, 64-bit wrap,
// truncated to the Sv39 virtual address plus a non-canonical flag.
module lsu_agu_adder
   import lsu_agu_pkg::*;
(
   input  logic [XLEN-1:0]             base_i,
   input  logic [IMM_LEN-1:0]          imm_i,
   output logic [VIRTUAL_ADDR_LEN-1:0] addr_o,
   output logic                        noncanon_o
);

   localparam int unsigned UpperLen = XLEN - VIRTUAL_ADDR_LEN;

   logic [XLEN-1:0] sum;

   // Sum and canonical check; upper bits must replicate the VA sign bit
   always_comb begin
      sum        = base_i + {{(XLEN-IMM_LEN){imm_i[IMM_LEN-1]}}, imm_i};
      addr_o     = sum[VIRTUAL_ADDR_LEN-1:0];
      noncanon_o = (sum[XLEN-1:VIRTUAL_ADDR_LEN] != {UpperLen{sum[VIRTUAL_ADDR_LEN-1]}});
   end

endmodule

// File: rtl/lsu_agu.sv
// LSU address-generation stage. Computes the virtual address for each issued
// op and registers it toward the address-check stage behind valid/ready.
// Build option LSU_AGU_SKID_EN: when defined, a skid register makes
// rcu_agu_ready_o a pure registered-state signal; otherwise a single pipeline
// register is used and ready depends combinationally on agu_ac_ready_i.
module lsu_agu
   import lsu_agu_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush_i,

   input  logic                        rcu_agu_valid_i,
   output logic                        rcu_agu_ready_o,
   input  logic                        rcu_agu_ls_i,
   input  logic [LS_OPCODE_WIDTH-1:0]  rcu_agu_opcode_i,
   input  logic [XLEN-1:0]             rcu_agu_base_i,
   input  logic [IMM_LEN-1:0]          rcu_agu_imm_i,
   input  logic [XLEN-1:0]             rcu_agu_data_i,
   input  logic [ROB_INDEX_WIDTH-1:0]  rcu_agu_rob_index_i,

   output logic                        agu_ac_valid_o,
   input  logic                        agu_ac_ready_i,
   output logic                        agu_ac_ls_o,
   output logic [LS_OPCODE_WIDTH-1:0]  agu_ac_opcode_o,
   output logic [XLEN-1:0]             agu_ac_data_o,
   output logic [ROB_INDEX_WIDTH-1:0]  agu_ac_rob_index_o,
   output logic [VIRTUAL_ADDR_LEN-1:0] agu_ac_addr_o,
   output logic                        agu_ac_noncanon_o
);

   logic [VIRTUAL_ADDR_LEN-1:0] in_addr;
   logic                        in_noncanon;
   agu_payload_t                in_payload;
   logic                        in_fire;

   agu_payload_t main_q, main_d;
   logic         main_valid_q, main_valid_d;

   lsu_agu_adder u_adder (
      .base_i     (rcu_agu_base_i),
      .imm_i      (rcu_agu_imm_i),
      .addr_o     (in_addr),
      .noncanon_o (in_noncanon)
   );

   // Pack the incoming op with its computed address
   always_comb begin
      in_payload.ls        = rcu_agu_ls_i;
      in_payload.opcode    = rcu_agu_opcode_i;
      in_payload.data      = rcu_agu_data_i;
      in_payload.rob_index = rcu_agu_rob_index_i;
      in_payload.addr      = in_addr;
      in_payload.noncanon  = in_noncanon;
   end

   assign in_fire = rcu_agu_valid_i & rcu_agu_ready_o;

`ifdef LSU_AGU_SKID_EN

   agu_payload_t skid_q, skid_d;
   logic         skid_valid_q, skid_valid_d;
   logic         out_fire;

   assign out_fire        = main_valid_q & agu_ac_ready_i;
   assign rcu_agu_ready_o = ~rst & ~skid_valid_q;

   // Main/skid steering: skid refills main first so FIFO order is kept;
   // skid is only written while main is held. Flush dominates.
   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_fire || !main_valid_q) begin
         if (skid_valid_q) begin
            // ready_o is low while skid is full, so no input competes here
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = in_fire;
            if (in_fire) begin
               main_d = in_payload;
            end
         end
      end else if (in_fire) begin
         skid_d       = in_payload;
         skid_valid_d = 1'b1;
      end
   end

   // Skid state register; only the valid bit is reset
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_valid_q <= 1'b0;
      end else begin
         skid_valid_q <= skid_valid_d;
      end
      skid_q <= skid_d;
   end

`else

   assign rcu_agu_ready_o = ~rst & (~main_valid_q | agu_ac_ready_i);

   // Single pipeline register: load whenever the slot is free or draining
   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      if (flush_i) begin
         main_valid_d = 1'b0;
      end else if (rcu_agu_ready_o) begin
         main_valid_d = rcu_agu_valid_i;
         if (in_fire) begin
            main_d = in_payload;
         end
      end
   end

`endif

   // Main state register; payload is deliberately left unreset
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
      end
      main_q <= main_d;
   end

   // Outputs driven straight from the main register
   always_comb begin
      agu_ac_valid_o     = main_valid_q;
      agu_ac_ls_o        = main_q.ls;
      agu_ac_opcode_o    = main_q.opcode;
      agu_ac_data_o      = main_q.data;
      agu_ac_rob_index_o = main_q.rob_index;
      agu_ac_addr_o      = main_q.addr;
      // Qualified so it reads 0 out of reset despite the unreset payload
      agu_ac_noncanon_o  = main_valid_q & main_q.noncanon;
   end

endmodule

// File: tb/tb_lsu_agu.sv
// Self-checking bench for lsu_agu (works with LSU_AGU_SKID_EN defined or not).
module tb_lsu_agu;
   import lsu_agu_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        flush_i;
   logic                        rcu_agu_valid_i;
   logic                        rcu_agu_ready_o;
   logic                        rcu_agu_ls_i;
   logic [LS_OPCODE_WIDTH-1:0]  rcu_agu_opcode_i;
   logic [XLEN-1:0]             rcu_agu_base_i;
   logic [IMM_LEN-1:0]          rcu_agu_imm_i;
   logic [XLEN-1:0]             rcu_agu_data_i;
   logic [ROB_INDEX_WIDTH-1:0]  rcu_agu_rob_index_i;
   logic                        agu_ac_valid_o;
   logic                        agu_ac_ready_i;
   logic                        agu_ac_ls_o;
   logic [LS_OPCODE_WIDTH-1:0]  agu_ac_opcode_o;
   logic [XLEN-1:0]             agu_ac_data_o;
   logic [ROB_INDEX_WIDTH-1:0]  agu_ac_rob_index_o;
   logic [VIRTUAL_ADDR_LEN-1:0] agu_ac_addr_o;
   logic                        agu_ac_noncanon_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [ROB_INDEX_WIDTH-1:0]  tag;
      logic [VIRTUAL_ADDR_LEN-1:0] addr;
      logic [XLEN-1:0]             data;
      logic                        nc;
      logic                        ls;
      logic [LS_OPCODE_WIDTH-1:0]  op;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   lsu_agu dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush_i             (flush_i),
      .rcu_agu_valid_i     (rcu_agu_valid_i),
      .rcu_agu_ready_o     (rcu_agu_ready_o),
      .rcu_agu_ls_i        (rcu_agu_ls_i),
      .rcu_agu_opcode_i    (rcu_agu_opcode_i),
      .rcu_agu_base_i      (rcu_agu_base_i),
      .rcu_agu_imm_i       (rcu_agu_imm_i),
      .rcu_agu_data_i      (rcu_agu_data_i),
      .rcu_agu_rob_index_i (rcu_agu_rob_index_i),
      .agu_ac_valid_o      (agu_ac_valid_o),
      .agu_ac_ready_i      (agu_ac_ready_i),
      .agu_ac_ls_o         (agu_ac_ls_o),
      .agu_ac_opcode_o     (agu_ac_opcode_o),
      .agu_ac_data_o       (agu_ac_data_o),
      .agu_ac_rob_index_o  (agu_ac_rob_index_o),
      .agu_ac_addr_o       (agu_ac_addr_o),
      .agu_ac_noncanon_o   (agu_ac_noncanon_o)
   );

   function automatic exp_t make_exp(input logic ls, input logic [LS_OPCODE_WIDTH-1:0] op,
                                     input logic [XLEN-1:0] base, input logic [IMM_LEN-1:0] imm,
                                     input logic [XLEN-1:0] data,
                                     input logic [ROB_INDEX_WIDTH-1:0] tag);
      logic [XLEN-1:0] s;
      exp_t e;
      s      = base + {{(XLEN-IMM_LEN){imm[IMM_LEN-1]}}, imm};
      e.tag  = tag;
      e.addr = s[VIRTUAL_ADDR_LEN-1:0];
      e.data = data;
      e.nc   = (s[XLEN-1:VIRTUAL_ADDR_LEN] != {(XLEN-VIRTUAL_ADDR_LEN){s[VIRTUAL_ADDR_LEN-1]}});
      e.ls   = ls;
      e.op   = op;
      return e;
   endfunction

   // Expected ready from the occupancy model and the current inputs
   function automatic logic model_ready();
`ifdef LSU_AGU_SKID_EN
      return !rst && (q.size() < 2);
`else
      return !rst && ((q.size() == 0) || agu_ac_ready_i);
`endif
   endfunction

   task automatic drive(input logic v, input logic ls, input logic [LS_OPCODE_WIDTH-1:0] op,
                        input logic [XLEN-1:0] base, input logic [IMM_LEN-1:0] imm,
                        input logic [XLEN-1:0] data, input logic [ROB_INDEX_WIDTH-1:0] tag,
                        input logic rdy, input logic fl);
      rcu_agu_valid_i     = v;
      rcu_agu_ls_i        = ls;
      rcu_agu_opcode_i    = op;
      rcu_agu_base_i      = base;
      rcu_agu_imm_i       = imm;
      rcu_agu_data_i      = data;
      rcu_agu_rob_index_i = tag;
      agu_ac_ready_i      = rdy;
      flush_i             = fl;
   endtask

   // Advance the occupancy model by the handshakes about to happen at posedge
   task automatic model_update();
      logic in_fire;
      in_fire = rcu_agu_valid_i && rcu_agu_ready_o;
      if (rst || flush_i) begin
         q.delete();
      end else begin
         if (agu_ac_valid_o && agu_ac_ready_i && q.size() > 0) void'(q.pop_front());
         if (in_fire) q.push_back(make_exp(rcu_agu_ls_i, rcu_agu_opcode_i, rcu_agu_base_i,
                                           rcu_agu_imm_i, rcu_agu_data_i, rcu_agu_rob_index_i));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b0, LDU_LD, 64'h1000, 12'h0, 64'h0, 6'd9, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (agu_ac_valid_o !== 1'b0 || agu_ac_noncanon_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs valid=%b noncanon=%b required 0/0",
                  agu_ac_valid_o, agu_ac_noncanon_o);
      end
      checks++;
      if (rcu_agu_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got=%b required 0", rcu_agu_ready_o);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, LDU_LD, 64'h0, 12'h0, 64'h0, 6'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (rcu_agu_ready_o !== 1'b1 || agu_ac_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL post_reset ready=%b valid=%b required 1/0",
                  rcu_agu_ready_o, agu_ac_valid_o);
      end
      q.delete();
   endtask

   task automatic test_addr();
      logic [XLEN-1:0]             tv_base [7];
      logic [IMM_LEN-1:0]          tv_imm  [7];
      logic [VIRTUAL_ADDR_LEN-1:0] tv_addr [7];
      logic                        tv_nc   [7];
      tv_base = '{64'h0000_0000_0000_1000, 64'h0000_003F_FFFF_FFFF, 64'hFFFF_FFC0_0000_0000,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 64'h0000_0080_0000_0000,
                  64'h7FFF_FFFF_FFFF_F000};
      tv_imm  = '{12'hFFC, 12'h001, 12'h000, 12'h001, 12'h800, 12'h000, 12'h7FF};
      tv_addr = '{39'h00_0000_0FFC, 39'h40_0000_0000, 39'h40_0000_0000, 39'h00_0000_0000,
                  39'h7F_FFFF_F800, 39'h00_0000_0000, 39'h7F_FFFF_F7FF};
      tv_nc   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, LDU_LD, tv_base[i], tv_imm[i], 64'hA5A5_0000_0000_0000 + 64'(i),
               6'(i + 10), 1'b1, 1'b0);
         @(negedge clk);
         drive(1'b0, 1'b0, LDU_LD, 64'h0, 12'h0, 64'h0, 6'd0, 1'b1, 1'b0);
         #1;
         checks++;
         if (agu_ac_valid_o !== 1'b1 || agu_ac_addr_o !== tv_addr[i] ||
             agu_ac_noncanon_o !== tv_nc[i] || agu_ac_rob_index_o !== 6'(i + 10) ||
             agu_ac_data_o !== 64'hA5A5_0000_0000_0000 + 64'(i) || agu_ac_opcode_o !== LDU_LD) begin
            failures++;
            $display("FAIL addr_vec%0d got v=%b addr=%h nc=%b tag=%0d data=%h op=%h required v=1 addr=%h nc=%b tag=%0d",
                     i, agu_ac_valid_o, agu_ac_addr_o, agu_ac_noncanon_o, agu_ac_rob_index_o,
                     agu_ac_data_o, agu_ac_opcode_o, tv_addr[i], tv_nc[i], i + 10);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (agu_ac_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL addr_drain valid=%b required 0", agu_ac_valid_o);
      end
      q.delete();
   endtask

   task automatic test_stream();
      int  idx      = 0;
      int  recv     = 0;
      logic saw_drop = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         drive(idx < 4, 1'(idx & 1), (idx & 1) ? STU_SD : LDU_LW, 64'h2000 + 64'(idx * 8),
               12'h010, 64'h1111 * 64'(idx + 1), 6'(idx + 1), !(c >= 1 && c <= 3), 1'b0);
         #1;
         checks++;
         if (agu_ac_valid_o !== (q.size() != 0) || rcu_agu_ready_o !== model_ready()) begin
            failures++;
            $display("FAIL stream_c%0d valid=%b ready=%b required %b/%b", c, agu_ac_valid_o,
                     rcu_agu_ready_o, q.size() != 0, model_ready());
         end
         if (rcu_agu_ready_o === 1'b0) saw_drop = 1'b1;
         if (agu_ac_valid_o === 1'b1 && agu_ac_ready_i) begin
            checks++;
            if (agu_ac_rob_index_o !== 6'(recv + 1) ||
                agu_ac_addr_o !== 39'(64'h2010 + 64'(recv * 8)) ||
                agu_ac_data_o !== 64'h1111 * 64'(recv + 1)) begin
               failures++;
               $display("FAIL stream_order tag=%0d addr=%h data=%h required tag=%0d addr=%h",
                        agu_ac_rob_index_o, agu_ac_addr_o, agu_ac_data_o, recv + 1,
                        64'h2010 + 64'(recv * 8));
            end
            recv++;
         end
         if (rcu_agu_valid_i && rcu_agu_ready_o) idx++;
         model_update();
      end
      checks++;
      if (recv != 4 || saw_drop !== 1'b1) begin
         failures++;
         $display("FAIL stream_count received=%0d ready_dropped=%b required 4/1", recv, saw_drop);
      end
   endtask

   task automatic test_flush(input logic use_rst);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, STU_SW, 64'h3000, 12'h004, 64'hDEAD_0000 + 64'(i), 6'(40 + i),
               1'b0, 1'b0);
         #1;
         model_update();
      end
      @(negedge clk);
      drive(1'b1, 1'b0, LDU_LB, 64'h4000, 12'h0, 64'hBEEF, 6'd42, 1'b1, !use_rst);
      rst = use_rst;
      #1;
      if (use_rst) begin
         checks++;
         if (rcu_agu_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ready got=%b required 0", rcu_agu_ready_o);
         end
      end
      model_update();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, LDU_LB, 64'h0, 12'h0, 64'h0, 6'd0, 1'b1, 1'b0);
      #1;
      checks++;
      if (agu_ac_valid_o !== 1'b0 || rcu_agu_ready_o !== 1'b1 || agu_ac_noncanon_o !== 1'b0) begin
         failures++;
         $display("FAIL kill_%s valid=%b ready=%b nc=%b required 0/1/0", use_rst ? "rst" : "flush",
                  agu_ac_valid_o, rcu_agu_ready_o, agu_ac_noncanon_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (agu_ac_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL kill_ghost tag=%0d appeared, required no output", agu_ac_rob_index_o);
         end
      end
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int cyc  = 0;
      while ((sent < 200 || q.size() != 0) && cyc < 3000) begin
         @(negedge clk);
         drive((sent < 200) && ($urandom_range(3) != 0), 1'($urandom), 4'($urandom),
               {$urandom, $urandom}, 12'($urandom), {$urandom, $urandom}, 6'(sent),
               (sent >= 200) || ($urandom_range(4) > 1), 1'b0);
         #1;
         checks++;
         if (agu_ac_valid_o !== (q.size() != 0) || rcu_agu_ready_o !== model_ready()) begin
            failures++;
            $display("FAIL b2b_hs cyc=%0d valid=%b ready=%b required %b/%b", cyc, agu_ac_valid_o,
                     rcu_agu_ready_o, q.size() != 0, model_ready());
         end
         if (agu_ac_valid_o === 1'b1 && q.size() != 0) begin
            checks++;
            if ({agu_ac_rob_index_o, agu_ac_addr_o, agu_ac_data_o, agu_ac_noncanon_o,
                 agu_ac_ls_o, agu_ac_opcode_o} !==
                {q[0].tag, q[0].addr, q[0].data, q[0].nc, q[0].ls, q[0].op}) begin
               failures++;
               $display("FAIL b2b_data tag=%0d addr=%h data=%h nc=%b required tag=%0d addr=%h data=%h nc=%b",
                        agu_ac_rob_index_o, agu_ac_addr_o, agu_ac_data_o, agu_ac_noncanon_o,
                        q[0].tag, q[0].addr, q[0].data, q[0].nc);
            end
         end
         if (rcu_agu_valid_i && rcu_agu_ready_o) sent++;
         model_update();
         cyc++;
      end
      checks++;
      if (sent != 200 || q.size() != 0) begin
         failures++;
         $display("FAIL b2b_complete sent=%0d pending=%0d required 200/0", sent, q.size());
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, LDU_LD, 64'h0, 12'h0, 64'h0, 6'd0, 1'b0, 1'b0);
      test_reset();
      test_addr();
      test_stream();
      test_flush(1'b0);
      test_flush(1'b1);
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
